// File: rtl/sram_1rw_port_arbiter_if.sv
// Requester-side handshake bundle for the 1RW SRAM arbiter.
// One instance per requester; rvalid pairs with the shared rsp_rdata.
interface sram_1rw_port_arbiter_if #(
  parameter int DATA_WIDTH = 136,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_WMASKS = 8
);
  logic                  valid;
  logic                  ready;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [NUM_WMASKS-1:0] wmask;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rvalid;

  modport master (
    output valid, we, addr, wmask, wdata,
    input  ready, rvalid
  );

  modport slave (
    input  valid, we, addr, wmask, wdata,
    output ready, rvalid
  );
endinterface

// File: rtl/sram_1rw_port_arbiter.sv
// Zero-fill sequencer and round-robin front-end for a 1RW SRAM macro.
// All macro pins come from flops; read data is captured two edges later.
module sram_1rw_port_arbiter #(
  parameter int DATA_WIDTH = 136,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_WMASKS = 8,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  sram_1rw_port_arbiter_if.slave p0,
  sram_1rw_port_arbiter_if.slave p1,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  typedef enum logic {INIT, RUN} state_t;

  localparam state_t RST_STATE = INIT_EN ? INIT : RUN;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  s1_rd_q, s1_rd_d;
  logic                  s1_port_q, s1_port_d;
  logic                  s2_rd_q, s2_port_q;
  logic [1:0]            rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  init_done_q;

  logic                  run;
  logic                  gnt0, gnt1;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [NUM_WMASKS-1:0] sel_wmask;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Grant: the port other than the last winner takes a tie.
  always_comb begin
    run       = (state_q == RUN);
    gnt0      = run && p0.valid && (!p1.valid || last_q);
    gnt1      = run && p1.valid && (!p0.valid || !last_q);
    sel_we    = gnt1 ? p1.we    : p0.we;
    sel_addr  = gnt1 ? p1.addr  : p0.addr;
    sel_wmask = gnt1 ? p1.wmask : p0.wmask;
    sel_wdata = gnt1 ? p1.wdata : p0.wdata;
  end

  assign p0.ready = gnt0;
  assign p1.ready = gnt1;

  // Next state: init sweep or one granted command onto the pins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    csb_d     = 1'b1;
    web_d     = 1'b1;
    wmask_d   = wmask_q;
    addr_d    = addr_q;
    din_d     = din_q;
    s1_rd_d   = 1'b0;
    s1_port_d = s1_port_q;
    unique case (state_q)
      INIT: begin
        csb_d   = 1'b0;
        web_d   = 1'b0;
        wmask_d = '1;
        din_d   = '0;
        addr_d  = cnt_q;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = RUN;
      end
      RUN: begin
        if (gnt0 || gnt1) begin
          csb_d     = 1'b0;
          web_d     = ~sel_we;
          addr_d    = sel_addr;
          last_d    = gnt1;
          s1_rd_d   = ~sel_we;
          s1_port_d = gnt1;
          if (sel_we) begin
            wmask_d = sel_wmask;
            din_d   = sel_wdata;
          end
        end
      end
      default: ;
    endcase
  end

  // Control state, macro pin flops and the issue-cycle read tag.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      wmask_q     <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      s1_rd_q     <= 1'b0;
      s1_port_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      wmask_q     <= wmask_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      s1_rd_q     <= s1_rd_d;
      s1_port_q   <= s1_port_d;
      init_done_q <= (state_d == RUN);
    end
  end

  // Read return: tag rides the macro cycle, dout0 taken one edge later.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      s2_rd_q   <= 1'b0;
      s2_port_q <= 1'b0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
    end else begin
      s2_rd_q     <= s1_rd_q;
      s2_port_q   <= s1_port_q;
      rvalid_q[0] <= s2_rd_q && !s2_port_q;
      rvalid_q[1] <= s2_rd_q && s2_port_q;
      if (s2_rd_q) rdata_q <= dout0;
    end
  end

  assign p0.rvalid = rvalid_q[0];
  assign p1.rvalid = rvalid_q[1];
  assign rsp_rdata = rdata_q;
  assign init_done = init_done_q;
  assign csb0      = csb_q;
  assign web0      = web_q;
  assign wmask0    = wmask_q;
  assign addr0     = addr_q;
  assign din0      = din_q;

endmodule

// File: tb/tb_sram_1rw_port_arbiter.sv
// Directed bench for sram_1rw_port_arbiter with a behavioural macro.
// Vector table covers arbitration and reads; init and reset by hand.
module tb_sram_1rw_port_arbiter;
  localparam int DW = 136;
  localparam int AW = 10;
  localparam int NM = 8;

  localparam logic [DW-1:0] Z    = '0;
  localparam logic [DW-1:0] ONES = '1;
  localparam logic [DW-1:0] PA   = {17{8'h5A}};
  localparam logic [DW-1:0] PB   = {17{8'hC3}};
  localparam logic [DW-1:0] MSK  =
    136'h1FFFF | (136'h1FFFF << 34);
  localparam logic [DW-1:0] JUNK = {17{8'hEE}};

  typedef struct {
    bit              v;
    bit              we;
    logic [AW-1:0]   a;
    logic [NM-1:0]   m;
    logic [DW-1:0]   d;
  } port_t;

  typedef struct {
    port_t           p0;
    port_t           p1;
    bit [1:0]        er;
    bit [1:0]        erv;
    logic [DW-1:0]   ed;
  } vec_t;

  logic clk0 = 1'b0;
  logic rst0_n = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic init_done;
  logic csb0, web0;
  logic [NM-1:0] wmask0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0 = '0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk0 = ~clk0;

  sram_1rw_port_arbiter_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM)
  ) if0 ();
  sram_1rw_port_arbiter_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM)
  ) if1 ();

  sram_1rw_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .NUM_WMASKS(NM), .INIT_EN(1'b1)
  ) dut (
    .clk0(clk0),
    .rst0_n(rst0_n),
    .p0(if0),
    .p1(if1),
    .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .csb0(csb0),
    .web0(web0),
    .wmask0(wmask0),
    .addr0(addr0),
    .din0(din0),
    .dout0(dout0)
  );

  // Macro model: samples pins at posedge, drives dout0 at next negedge.
  logic [DW-1:0] mem [1024];
  logic [AW-1:0] raddr = '0;
  logic          rpend = 1'b0;

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] old, input logic [DW-1:0] nw,
    input logic [NM-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int l = 0; l < NM; l++)
      if (m[l]) r[l*17 +: 17] = nw[l*17 +: 17];
    return r;
  endfunction

  always @(posedge clk0) begin
    rpend <= !csb0 && web0;
    if (!csb0) begin
      if (!web0) mem[addr0] <= merge(mem[addr0], din0, wmask0);
      else raddr <= addr0;
    end
  end

  always @(negedge clk0)
    dout0 <= rpend ? mem[raddr] : JUNK;

  task automatic check(input string nm,
                       input logic [159:0] act,
                       input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic port_t NOP();
    port_t p;
    p = '{v: 1'b0, we: 1'b0, a: '0, m: '0, d: '0};
    return p;
  endfunction

  function automatic port_t RD(input logic [AW-1:0] a);
    port_t p;
    p = '{v: 1'b1, we: 1'b0, a: a, m: '0, d: '0};
    return p;
  endfunction

  function automatic port_t WR(input logic [AW-1:0] a,
                               input logic [NM-1:0] m,
                               input logic [DW-1:0] d);
    port_t p;
    p = '{v: 1'b1, we: 1'b1, a: a, m: m, d: d};
    return p;
  endfunction

  function automatic vec_t mk(input port_t a, input port_t b,
                              input bit [1:0] er, input bit [1:0] erv,
                              input logic [DW-1:0] ed);
    vec_t v;
    v.p0 = a; v.p1 = b; v.er = er; v.erv = erv; v.ed = ed;
    return v;
  endfunction

  task automatic drive(input port_t a, input port_t b);
    if0.valid = a.v; if0.we = a.we; if0.addr = a.a;
    if0.wmask = a.m; if0.wdata = a.d;
    if1.valid = b.v; if1.we = b.we; if1.addr = b.a;
    if1.wmask = b.m; if1.wdata = b.d;
  endtask

  task automatic chk_reset_vals();
    check("rst_pins", {csb0, web0, wmask0, addr0, din0},
          {1'b1, 1'b1, 8'h00, 10'h000, Z});
    check("rst_rdata", rsp_rdata, Z);
    check("rst_done", init_done, 1'b0);
    check("rst_rv", {if0.rvalid, if1.rvalid}, 2'b00);
    check("rst_ready", {if0.ready, if1.ready}, 2'b00);
  endtask

  task automatic chk_init();
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk0);
      check("init_pins", {csb0, web0, wmask0, addr0, din0},
            {1'b0, 1'b0, 8'hFF, i[AW-1:0], Z});
      check("init_done", init_done, (i == 1023));
      check("init_rv", {if0.rvalid, if1.rvalid}, 2'b00);
    end
  endtask

  vec_t q[$];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    q.push_back(mk(RD(10'h3FF), NOP(), 2'b10, 2'b00, Z));
    q.push_back(mk(NOP(), NOP(), 2'b00, 2'b00, Z));
    q.push_back(mk(NOP(), NOP(), 2'b00, 2'b10, Z));
    q.push_back(mk(WR(10'h3FF, 8'hFF, PA), NOP(), 2'b10, 2'b00, Z));
    q.push_back(mk(RD(10'h3FF), NOP(), 2'b10, 2'b00, Z));
    q.push_back(mk(NOP(), NOP(), 2'b00, 2'b00, Z));
    q.push_back(mk(NOP(), NOP(), 2'b00, 2'b10, PA));
    q.push_back(mk(NOP(), RD(10'h3FF), 2'b01, 2'b00, Z));
    q.push_back(mk(NOP(), NOP(), 2'b00, 2'b00, Z));
    q.push_back(mk(NOP(), NOP(), 2'b00, 2'b01, PA));
    q.push_back(mk(NOP(), WR(10'h005, 8'hFF, PB), 2'b01, 2'b00, Z));
    q.push_back(mk(RD(10'h3FF), RD(10'h005), 2'b10, 2'b00, Z));
    q.push_back(mk(RD(10'h3FF), RD(10'h005), 2'b01, 2'b00, Z));
    q.push_back(mk(RD(10'h3FF), RD(10'h005), 2'b10, 2'b10, PA));
    q.push_back(mk(RD(10'h3FF), RD(10'h005), 2'b01, 2'b01, PB));
    q.push_back(mk(RD(10'h3FF), RD(10'h005), 2'b10, 2'b10, PA));
    q.push_back(mk(RD(10'h3FF), RD(10'h005), 2'b01, 2'b01, PB));
    q.push_back(mk(NOP(), NOP(), 2'b00, 2'b10, PA));
    q.push_back(mk(NOP(), NOP(), 2'b00, 2'b01, PB));
    q.push_back(mk(WR(10'h007, 8'h05, ONES), NOP(), 2'b10, 2'b00, Z));
    q.push_back(mk(RD(10'h007), NOP(), 2'b10, 2'b00, Z));
    q.push_back(mk(NOP(), WR(10'h3FF, 8'hFF, PB), 2'b01, 2'b00, Z));
    q.push_back(mk(RD(10'h3FF), NOP(), 2'b10, 2'b10, MSK));
    q.push_back(mk(NOP(), NOP(), 2'b00, 2'b00, Z));
    q.push_back(mk(NOP(), NOP(), 2'b00, 2'b10, PB));
    q.push_back(mk(WR(10'h3FF, 8'h00, ONES), NOP(), 2'b10, 2'b00, Z));
    q.push_back(mk(RD(10'h3FF), NOP(), 2'b10, 2'b00, Z));
    q.push_back(mk(NOP(), NOP(), 2'b00, 2'b00, Z));
    q.push_back(mk(NOP(), NOP(), 2'b00, 2'b10, PB));
    q.push_back(mk(WR(10'h009, 8'hFF, PA), RD(10'h005),
                   2'b01, 2'b00, Z));
    q.push_back(mk(WR(10'h009, 8'hFF, PA), RD(10'h005),
                   2'b10, 2'b00, Z));
    q.push_back(mk(NOP(), NOP(), 2'b00, 2'b01, PB));
    q.push_back(mk(NOP(), NOP(), 2'b00, 2'b00, Z));

    // Reset state, with requests already waiting.
    drive(RD(10'h001), RD(10'h002));
    #12;
    chk_reset_vals();
    @(negedge clk0);
    drive(NOP(), NOP());
    rst0_n = 1'b1;
    chk_init();

    // Table: ready checked before the edge, responses after it.
    foreach (q[i]) begin
      drive(q[i].p0, q[i].p1);
      #1;
      check($sformatf("ready[%0d]", i),
            {if0.ready, if1.ready}, q[i].er);
      @(negedge clk0);
      check($sformatf("rvalid[%0d]", i),
            {if0.rvalid, if1.rvalid}, q[i].erv);
      if (q[i].erv != 2'b00)
        check($sformatf("rdata[%0d]", i), rsp_rdata, q[i].ed);
    end
    drive(NOP(), NOP());

    // Reset one cycle after a read is accepted, with another in flight.
    drive(RD(10'h3FF), NOP());
    #1;
    check("mid_ready", if0.ready, 1'b1);
    @(posedge clk0);
    @(negedge clk0);
    check("mid_issue", {csb0, web0}, 2'b01);
    @(posedge clk0);
    #1;
    check("mid_csb_pre", csb0, 1'b0);
    rst0_n = 1'b0;
    #1;
    chk_reset_vals();
    drive(NOP(), NOP());
    for (int k = 0; k < 3; k++) begin
      @(negedge clk0);
      check("mid_rv", {if0.rvalid, if1.rvalid}, 2'b00);
      check("mid_csb", csb0, 1'b1);
    end
    rst0_n = 1'b1;
    chk_init();
    repeat (3) begin
      @(negedge clk0);
      check("post_rv", {if0.rvalid, if1.rvalid}, 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_1rw_port_arbiter.md
# sram_1rw_port_arbiter

Sequencing front-end for the 1024x136 single-port (1RW) SRAM macro with 8 write-mask lanes. It zero-initialises the array after reset, then shares the macro's only RW port between two requesters using round-robin arbitration. It registers every macro input and captures read data at the single safe clock edge, then returns the data to the requester that issued the read. It sits between the two requesters and the macro instance; it is the only driver of the macro pins.

## Interface
- DATA_WIDTH, 136, word width; must equal NUM_WMASKS*17
- ADDR_WIDTH, 10, address width; array depth is 1<<ADDR_WIDTH
- NUM_WMASKS, 8, write-mask lanes, 17 bits each
- INIT_EN, 1, 1 = zero-fill the array after reset; 0 = go straight to RUN
- clk0  in  1  single clock; also drives the macro clk0
- rst0_n  in  1  asynchronous, active-low reset
- pN_valid  in  1  request valid (N = 0, 1)
- pN_ready  out  1  request accepted this cycle
- pN_we  in  1  1 = write, 0 = read
- pN_addr  in  ADDR_WIDTH  word address
- pN_wmask  in  NUM_WMASKS  lane enables, writes only
- pN_wdata  in  DATA_WIDTH  write data
- pN_rvalid  out  1  one-cycle read-response strobe
- rsp_rdata  out  DATA_WIDTH  read data shared by both ports; qualified by pN_rvalid
- init_done  out  1  array initialised; requests may be accepted
- csb0, web0, wmask0, addr0, din0  out  1/1/NUM_WMASKS/ADDR_WIDTH/DATA_WIDTH  macro port, all driven directly from flops
- dout0  in  DATA_WIDTH  macro read data

## Operation
- FSM states: INIT and RUN. Reset enters INIT if INIT_EN=1, otherwise RUN.
- INIT:
  - 10-bit counter cnt runs 0..1023.
  - Each cycle issues a write with csb0=0, web0=0, wmask0=all ones, din0=0, addr0=cnt.
  - After the write with cnt=1023 is issued, the FSM moves to RUN and init_done rises.
  - pN_ready is 0 throughout INIT.
- RUN arbitration:
  - A requester is granted when it is valid and wins arbitration. Then pN_ready=1 and the request is accepted that cycle.
  - Ready is combinational from the two valid inputs, the priority pointer and the FSM state.
  - At most one grant per cycle.
- Round robin:
  - Pointer `last` resets to 1, so port 0 wins the first contention.
  - When both ports are valid, the port not equal to `last` wins.
  - `last` updates only on a grant.
- Command issue:
  - The accepted request is registered onto the macro pins for exactly one cycle.
  - Pin values: csb0=0, web0=~we, addr0=addr.
  - Writes: wmask0=wmask, din0=wdata.
  - Reads: wmask0 and din0 hold their previous values.
- Idle cycles: csb0=1, web0=1; the other macro pins hold their values.
- Read return pipeline:
  - Stage S1 holds {read, port} alongside the issued command.
  - Stage S2 captures dout0 into rsp_rdata and asserts pN_rvalid for the matching port.
- No response backpressure. Requesters must sink pN_rvalid the cycle it is asserted.
- Writes produce no response.
- Ordering:
  - Commands execute in grant order.
  - A read granted the cycle after a write to the same address returns the new data.
- Write mask: a write with wmask=0 is still issued with csb0=0 and modifies nothing.

## Timing
- Reset values:
  - csb0=1, web0=1, wmask0=0, addr0=0, din0=0
  - pN_ready=0, pN_rvalid=0, rsp_rdata=0
  - init_done=0, cnt=0
- Acceptance edge P: command on the macro pins during cycle P..P+1. The macro samples at P+1.
- dout0 is valid after the negedge following P+1 and until shortly after P+2. The controller captures it at edge P+2.
- Read latency: pN_rvalid is high for one cycle after edge P+2 (2 cycles from acceptance).
- Throughput: one command per cycle; back-to-back reads return one per cycle.
- INIT duration: 1024 cycles. init_done rises on the edge that issues address 1023. The first request can be accepted on the following edge.
- Reset asserted mid-operation:
  - All outputs return to reset values asynchronously.
  - In-flight reads are dropped and produce no pN_rvalid.
  - INIT restarts from 0.

## Test plan
- INIT: after reset release, exactly 1024 write cycles with addresses 0..1023, wmask0=8'hFF, din0=0. init_done then =1. A read of address 1023 returns 0.
- Single port: p0 writes 0x5A.. pattern to address 0x3FF, then reads it back. p0_rvalid pulses exactly 2 cycles after the read is accepted, with matching data. p1_rvalid stays 0.
- Contention: both ports hold valid reads for 6 cycles. Grants alternate 0,1,0,1,0,1 and the responses alternate with the same 2-cycle latency.
- Masked write: after INIT, write all-ones with wmask=8'b0000_0101, then read. Bits [16:0] and [50:34] are 1 and all other bits are 0.
- Write-then-read: write to address A is accepted at edge P, read of A at edge P+1. The read returns the new data at P+3.
- Mid-operation reset: assert rst0_n low one cycle after a read is accepted. No pN_rvalid appears, csb0 goes to 1 immediately, and INIT reruns all 1024 writes.
